// File: rtl/verdict_stream_join.sv
// verdict_stream_join: joins a per-packet verdict stream with an AXI4-Stream packet stream, forwarding or dropping whole packets with the verdict tag stamped into tuser
module verdict_stream_join #(
  parameter int DATA_W    = 256,
  parameter int USER_W    = 12,
  parameter int VERDICT_W = 4,
  parameter int CNT_W     = 32
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 in_tvalid,
  output logic                 in_tready,
  input  logic [DATA_W-1:0]    in_tdata,
  input  logic [DATA_W/8-1:0]  in_tkeep,
  input  logic                 in_tlast,
  input  logic [USER_W-1:0]    in_tuser,
  input  logic                 verdict_valid,
  output logic                 verdict_ready,
  input  logic [VERDICT_W-1:0] verdict_data,
  output logic                 out_tvalid,
  input  logic                 out_tready,
  output logic [DATA_W-1:0]    out_tdata,
  output logic [DATA_W/8-1:0]  out_tkeep,
  output logic                 out_tlast,
  output logic [USER_W-1:0]    out_tuser,
  input  logic [1:0]           cfg_mode,
  output logic [CNT_W-1:0]     pass_pkts,
  output logic [CNT_W-1:0]     drop_pkts
);
  typedef enum logic [1:0] {HEAD, PASS, DROP} state_t;
  state_t state, state_n;
  logic en, vh_valid, d_pass, acc, head_acc, fwd, pop, skid_valid, skid_last;
  logic [VERDICT_W-1:0] vh_data;
  logic [VERDICT_W-2:0] tag_q, tag;
  logic [USER_W-1:0] user_st, skid_user;
  logic [DATA_W-1:0] skid_data;
  logic [DATA_W/8-1:0] skid_keep;
  assign d_pass = (cfg_mode == 2'd1) | ((cfg_mode != 2'd2) & vh_data[0]);
  assign in_tready = (state == HEAD) ? vh_valid & (~d_pass | ~skid_valid) :
                     (state == PASS) ? ~skid_valid : (state == DROP);
  assign acc = in_tvalid & in_tready;
  assign head_acc = acc & (state == HEAD);
  assign fwd = acc & ((state == PASS) | ((state == HEAD) & d_pass));
  assign tag = (state == HEAD) ? vh_data[VERDICT_W-1:1] : tag_q;
  assign user_st = {in_tuser[USER_W-1:VERDICT_W-1], tag};
  assign verdict_ready = en & (~vh_valid | head_acc);
  assign pop = out_tvalid & out_tready;
  always_comb begin
    state_n = state;
    if (acc)
      state_n = in_tlast ? HEAD : (state == HEAD) ? (d_pass ? PASS : DROP) : state;
  end
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state      <= HEAD;
      en         <= 1'b0;
      vh_valid   <= 1'b0;
      vh_data    <= '0;
      tag_q      <= '0;
      pass_pkts  <= '0;
      drop_pkts  <= '0;
      out_tvalid <= 1'b0;
      out_tdata  <= '0;
      out_tkeep  <= '0;
      out_tlast  <= 1'b0;
      out_tuser  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_keep  <= '0;
      skid_last  <= 1'b0;
      skid_user  <= '0;
    end else begin
      state <= state_n;
      en    <= 1'b1;
      if (verdict_valid & verdict_ready) begin
        vh_valid <= 1'b1;
        vh_data  <= verdict_data;
      end else if (head_acc) begin
        vh_valid <= 1'b0;
      end
      if (head_acc)
        tag_q <= vh_data[VERDICT_W-1:1];
      if (acc & in_tlast & fwd)
        pass_pkts <= pass_pkts + CNT_W'(1);
      if (acc & in_tlast & ~fwd)
        drop_pkts <= drop_pkts + CNT_W'(1);
      if (skid_valid) begin
        if (pop) begin
          out_tdata  <= skid_data;
          out_tkeep  <= skid_keep;
          out_tlast  <= skid_last;
          out_tuser  <= skid_user;
          skid_valid <= 1'b0;
        end
      end else if (fwd) begin
        if (~out_tvalid | pop) begin
          out_tvalid <= 1'b1;
          out_tdata  <= in_tdata;
          out_tkeep  <= in_tkeep;
          out_tlast  <= in_tlast;
          out_tuser  <= user_st;
        end else begin
          skid_valid <= 1'b1;
          skid_data  <= in_tdata;
          skid_keep  <= in_tkeep;
          skid_last  <= in_tlast;
          skid_user  <= user_st;
        end
      end else if (pop) begin
        out_tvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_verdict_stream_join.sv
// tb_verdict_stream_join: directed self-checking bench for verdict_stream_join
module tb_verdict_stream_join;
  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic [11:0] u;
  } beat_t;
  logic ap_clk = 1'b0, ap_rst_n = 1'b0;
  logic in_tvalid = 1'b0, in_tready, in_tlast = 1'b0;
  logic [31:0] in_tdata = '0;
  logic [3:0] in_tkeep = '0;
  logic [11:0] in_tuser = '0;
  logic verdict_valid = 1'b0, verdict_ready;
  logic [3:0] verdict_data = '0;
  logic out_tvalid, out_tready = 1'b1, out_tlast;
  logic [31:0] out_tdata;
  logic [3:0] out_tkeep;
  logic [11:0] out_tuser;
  logic [1:0] cfg_mode = 2'd0;
  logic [7:0] pass_pkts, drop_pkts;
  beat_t bq[$], cq[$], eq[$], held, cur;
  logic [3:0] vq[$];
  int vectors = 0, miscompares = 0, stalls = 0, accepts = 0, rdy_mode = 0;
  logic mon_en = 1'b0, in_fire = 1'b0, v_fire = 1'b0, o_fire = 1'b0, hold_chk = 1'b0, prev_rst = 1'b0;
  always #5 ap_clk = ~ap_clk;
  verdict_stream_join #(.DATA_W(32), .USER_W(12), .VERDICT_W(4), .CNT_W(8)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata), .in_tkeep(in_tkeep),
    .in_tlast(in_tlast), .in_tuser(in_tuser),
    .verdict_valid(verdict_valid), .verdict_ready(verdict_ready), .verdict_data(verdict_data),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata), .out_tkeep(out_tkeep),
    .out_tlast(out_tlast), .out_tuser(out_tuser),
    .cfg_mode(cfg_mode), .pass_pkts(pass_pkts), .drop_pkts(drop_pkts)
  );
  assign cur = {out_tdata, out_tkeep, out_tlast, out_tuser};
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [11:0] stamp(input logic [11:0] u, input logic [2:0] t);
    return {u[11:3], t};
  endfunction
  task automatic step(input int n);
    repeat (n) @(posedge ap_clk);
    #2;
  endtask
  task automatic pkt(input logic [31:0] base, input int n, input logic [11:0] ub, input logic fw, input logic [2:0] t);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d = base + 32'(i);
      b.k = 4'hF ^ 4'(i);
      b.l = (i == n - 1);
      b.u = ub + 12'(i);
      bq.push_back(b);
      if (fw) begin
        b.u = stamp(b.u, t);
        eq.push_back(b);
      end
    end
  endtask
  task automatic check_out(input string tag);
    chk({tag, "_count"}, 64'(cq.size()), 64'(eq.size()));
    for (int i = 0; i < cq.size() && i < eq.size(); i++)
      chk(tag, cq[i], eq[i]);
    cq.delete();
    eq.delete();
  endtask
  always @(negedge ap_clk) begin
    if (hold_chk && ap_rst_n && prev_rst) begin
      chk("stall_valid", out_tvalid, 1);
      chk("stall_beat", cur, held);
    end
    hold_chk = out_tvalid & ~out_tready;
    held = cur;
    prev_rst = ap_rst_n;
    in_fire = in_tvalid & in_tready;
    v_fire = verdict_valid & verdict_ready;
    o_fire = out_tvalid & out_tready;
    if (o_fire) cq.push_back(cur);
    if (mon_en) begin
      if (in_tvalid & ~in_tready) stalls++;
      if (in_fire) accepts++;
    end
  end
  always begin
    @(posedge ap_clk);
    #1;
    if (in_fire && bq.size() > 0) void'(bq.pop_front());
    if (v_fire && vq.size() > 0) void'(vq.pop_front());
    in_tvalid = bq.size() > 0;
    if (bq.size() > 0) {in_tdata, in_tkeep, in_tlast, in_tuser} = bq[0];
    else {in_tdata, in_tkeep, in_tlast, in_tuser} = '0;
    verdict_valid = vq.size() > 0;
    if (vq.size() > 0) verdict_data = vq[0];
    else verdict_data = '0;
    out_tready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  end
  initial begin
    step(3);
    chk("rst_in_tready", in_tready, 0);
    chk("rst_verdict_ready", verdict_ready, 0);
    chk("rst_out_tvalid", out_tvalid, 0);
    chk("rst_out_tdata", out_tdata, 0);
    chk("rst_pass", pass_pkts, 0);
    chk("rst_drop", drop_pkts, 0);
    ap_rst_n = 1'b1;
    step(2);
    vq.push_back(4'b0011);
    vq.push_back(4'b0000);
    pkt(32'h1, 3, 12'h123, 1'b1, 3'b001);
    pkt(32'h4, 3, 12'h456, 1'b0, 3'b000);
    step(20);
    check_out("t1_beat");
    chk("t1_pass", pass_pkts, 1);
    chk("t1_drop", drop_pkts, 1);
    stalls = 0;
    accepts = 0;
    mon_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      vq.push_back((i % 2 == 0) ? 4'b0001 : 4'b0000);
      pkt(32'h100 + 32'(i), 1, 12'(i), (i % 2 == 0), 3'b000);
    end
    step(110);
    mon_en = 1'b0;
    chk("t2_stalls", 64'(stalls), 1);
    chk("t2_accepts", 64'(accepts), 100);
    check_out("t2_beat");
    chk("t2_pass", pass_pkts, 51);
    chk("t2_drop", drop_pkts, 51);
    rdy_mode = 1;
    vq.push_back(4'b1001);
    pkt(32'hA000, 16, 12'h3F0, 1'b1, 3'b100);
    step(200);
    rdy_mode = 0;
    step(2);
    check_out("t3_beat");
    chk("t3_pass", pass_pkts, 52);
    pkt(32'hB0, 2, 12'hABC, 1'b1, 3'b010);
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("t4_data_wait_tready", in_tready, 0);
      chk("t4_data_wait_tvalid", out_tvalid, 0);
    end
    vq.push_back(4'b0101);
    step(10);
    check_out("t4a_beat");
    vq.push_back(4'b0000);
    step(2);
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("t4_vh_full_ready", verdict_ready, 0);
      chk("t4_vh_wait_tvalid", out_tvalid, 0);
    end
    pkt(32'hB8, 2, 12'h111, 1'b0, 3'b000);
    step(10);
    check_out("t4b_beat");
    chk("t4_pass", pass_pkts, 53);
    chk("t4_drop", drop_pkts, 52);
    cfg_mode = 2'd2;
    for (int i = 0; i < 5; i++) begin
      vq.push_back(4'b0001);
      pkt(32'hC00 + 32'(i * 2), 2, 12'h200, 1'b0, 3'b000);
    end
    step(30);
    chk("t5_verdicts_left", 64'(vq.size()), 0);
    chk("t5_beats_left", 64'(bq.size()), 0);
    check_out("t5_beat");
    chk("t5_drop", drop_pkts, 57);
    vq.push_back(4'b0001);
    pkt(32'hC0, 4, 12'h300, 1'b0, 3'b000);
    vq.push_back(4'b0000);
    pkt(32'hD0, 1, 12'hFFF, 1'b1, 3'b000);
    step(3);
    cfg_mode = 2'd1;
    step(12);
    check_out("t5_mode_beat");
    chk("t5_mode_pass", pass_pkts, 54);
    chk("t5_mode_drop", drop_pkts, 58);
    cfg_mode = 2'd0;
    rdy_mode = 2;
    vq.push_back(4'b0001);
    pkt(32'hF0, 8, 12'h050, 1'b0, 3'b000);
    step(6);
    ap_rst_n = 1'b0;
    step(1);
    chk("t6_rst_tvalid", out_tvalid, 0);
    chk("t6_rst_tdata", out_tdata, 0);
    chk("t6_rst_tuser", out_tuser, 0);
    chk("t6_rst_tlast", out_tlast, 0);
    chk("t6_rst_in_tready", in_tready, 0);
    chk("t6_rst_verdict_ready", verdict_ready, 0);
    chk("t6_rst_pass", pass_pkts, 0);
    chk("t6_rst_drop", drop_pkts, 0);
    bq.delete();
    vq.delete();
    cq.delete();
    eq.delete();
    step(1);
    ap_rst_n = 1'b1;
    rdy_mode = 0;
    vq.push_back(4'b1111);
    pkt(32'hE0, 2, 12'h00F, 1'b1, 3'b111);
    step(10);
    check_out("t6_beat");
    chk("t6_pass", pass_pkts, 1);
    chk("t6_drop", drop_pkts, 0);
    for (int i = 0; i < 254; i++) begin
      vq.push_back(4'b0001);
      pkt(32'h1000 + 32'(i), 1, 12'(i), 1'b1, 3'b000);
    end
    step(300);
    chk("wrap_pre", pass_pkts, 255);
    vq.push_back(4'b0001);
    pkt(32'h2000, 1, 12'h001, 1'b1, 3'b000);
    step(6);
    chk("wrap_zero", pass_pkts, 0);
    check_out("wrap_beat");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
